// File: rtl/hamming_pkg.sv
// Shared helpers for the extended-Hamming SECDED codec: width derivation,
// check-bit position test, payload bit placement and error classification.
package hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CORR,
    ERR_UNCORR
  } err_t;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int par_w(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic int cw_w(input int data_w);
    return data_w + par_w(data_w) + 1;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position of payload bit idx; payload fills non-power-of-two slots from 3 upward.
  function automatic int data_pos(input int idx);
    int pos;
    int n;
    pos = 2;
    n   = -1;
    while (n < idx) begin
      pos++;
      if (!is_pow2(pos)) n++;
    end
    return pos;
  endfunction

  localparam int DEFAULT_DATA_W = 4;
  localparam int S_W            = par_w(DEFAULT_DATA_W);

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity computation for one extended-Hamming codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int PAR_W  = par_w(DATA_W),
  localparam int CW_W   = cw_w(DATA_W)
) (
  input  logic [CW_W-1:0]  code,
  output logic [PAR_W-1:0] syn,
  output logic             par
);

  // Syndrome is the XOR of the positions of every set bit.
  always_comb begin
    syn = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (code[i]) syn = syn ^ PAR_W'(i);
    end
  end

  assign par = ^code;

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined SECDED decoder with valid/ready on both sides.
// Optional error counters are enabled by defining HAMMING_SECDED_STATS_EN.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
`ifdef HAMMING_SECDED_STATS_EN
  parameter  int CNT_W  = 16,
`endif
  localparam int PAR_W  = par_w(DATA_W),
  localparam int CW_W   = cw_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr
`ifdef HAMMING_SECDED_STATS_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

  logic              advance;
  logic [PAR_W-1:0]  syn;
  logic              par;
  logic [DATA_W-1:0] in_raw;

  logic              s1_valid;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic [DATA_W-1:0] s1_raw;

  err_t              err;
  logic              flip_en;
  logic [DATA_W-1:0] fix_data;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code (in_code),
    .syn  (syn),
    .par  (par)
  );

  // Check bits are fully consumed by the syndrome, so only payload bits travel on.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
    assign in_raw[gi] = in_code[data_pos(gi)];
  end

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (advance) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_syn <= syn;
      s1_par <= par;
      s1_raw <= in_raw;
    end
  end

  // Odd parity with a syndrome outside the codeword means three or more flips.
  always_comb begin
    err = ERR_NONE;
    if (s1_par) begin
      if (int'(s1_syn) < CW_W) err = ERR_CORR;
      else                     err = ERR_UNCORR;
    end else if (s1_syn != '0) begin
      err = ERR_UNCORR;
    end
  end

  assign flip_en = (err == ERR_CORR);

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fix
    assign fix_data[gi] = s1_raw[gi] ^ (flip_en && (s1_syn == PAR_W'(data_pos(gi))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data   <= (err == ERR_UNCORR) ? s1_raw : fix_data;
        out_corr   <= (err == ERR_CORR);
        out_uncorr <= (err == ERR_UNCORR);
      end
    end
  end

`ifdef HAMMING_SECDED_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid & out_ready;

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_xfer) begin
      if (out_corr && (corr_cnt != '1))     corr_cnt   <= corr_cnt + 1'b1;
      if (out_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Scoreboard bench for hamming_secded_dec at DATA_W=4, 8 and 11.
module tb_hamming_secded_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DATA_W=4 instance (CW_W=8)
  logic       iv4 = 1'b0, ordy4 = 1'b1;
  logic [7:0] code4 = '0;
  logic       rdy4, ov4, c4, u4;
  logic [3:0] od4;
`ifdef HAMMING_SECDED_STATS_EN
  logic       clr4 = 1'b0;
  logic [1:0] cc4, uc4;
`endif
  logic [5:0] q4[$];

  // DATA_W=8 instance (CW_W=13)
  logic        iv8 = 1'b0, ordy8 = 1'b1;
  logic [12:0] code8 = '0;
  logic        rdy8, ov8, c8, u8;
  logic [7:0]  od8;
`ifdef HAMMING_SECDED_STATS_EN
  logic [15:0] cc8, uc8;
`endif
  logic [9:0]  q8[$];

  // DATA_W=11 instance (CW_W=16)
  logic        iv16 = 1'b0, ordy16 = 1'b1;
  logic [15:0] code16 = '0;
  logic        rdy16, ov16, c16, u16;
  logic [10:0] od16;
`ifdef HAMMING_SECDED_STATS_EN
  logic [15:0] cc16, uc16;
`endif
  logic [12:0] q16[$];

  hamming_secded_dec #(.DATA_W(4)
`ifdef HAMMING_SECDED_STATS_EN
    , .CNT_W(2)
`endif
  ) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .in_code(code4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_corr(c4), .out_uncorr(u4)
`ifdef HAMMING_SECDED_STATS_EN
    , .cnt_clr(clr4), .corr_cnt(cc4), .uncorr_cnt(uc4)
`endif
  );

  hamming_secded_dec #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .in_code(code8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_corr(c8), .out_uncorr(u8)
`ifdef HAMMING_SECDED_STATS_EN
    , .cnt_clr(1'b0), .corr_cnt(cc8), .uncorr_cnt(uc8)
`endif
  );

  hamming_secded_dec #(.DATA_W(11)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .in_code(code16),
    .out_valid(ov16), .out_ready(ordy16), .out_data(od16), .out_corr(c16), .out_uncorr(u16)
`ifdef HAMMING_SECDED_STATS_EN
    , .cnt_clr(1'b0), .corr_cnt(cc16), .uncorr_cnt(uc16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask

  // Reference encoder / extractor, written from the codeword layout.
  function automatic int pw(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic logic [15:0] enc(input int dw, input logic [15:0] d);
    logic [15:0] c;
    logic        b;
    int          cw;
    int          k;
    cw = dw + pw(dw) + 1;
    c  = '0;
    k  = 0;
    for (int pos = 1; pos < cw; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int j = 0; (1 << j) < cw; j++) begin
      b = 1'b0;
      for (int pos = 1; pos < cw; pos++) if ((pos & (1 << j)) != 0) b ^= c[pos];
      c[1 << j] = b;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [15:0] ext(input int dw, input logic [15:0] c);
    logic [15:0] d;
    int          cw;
    int          k;
    cw = dw + pw(dw) + 1;
    d  = '0;
    k  = 0;
    for (int pos = 1; pos < cw; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos];
        k++;
      end
    end
    return d;
  endfunction

  // Callers are always at posedge+1 so stimulus never races the sampling edge.
  task automatic send4(input logic [7:0] c, input logic [3:0] d, input logic co, input logic un);
    int g;
    g = 0;
    iv4 = 1'b1;
    code4 = c;
    @(negedge clk);
    while (!rdy4 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("w4_accept", 32'(rdy4), 32'd1);
    if (rdy4) q4.push_back({d, co, un});
    @(posedge clk);
    #1 iv4 = 1'b0;
  endtask

  task automatic send8(input logic [12:0] c, input logic [7:0] d, input logic co, input logic un);
    int g;
    g = 0;
    iv8 = 1'b1;
    code8 = c;
    @(negedge clk);
    while (!rdy8 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!rdy8) chk("w8_accept", 32'(rdy8), 32'd1);
    else q8.push_back({d, co, un});
    @(posedge clk);
    #1 iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] c, input logic [10:0] d, input logic co, input logic un);
    int g;
    g = 0;
    iv16 = 1'b1;
    code16 = c;
    @(negedge clk);
    while (!rdy16 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!rdy16) chk("w16_accept", 32'(rdy16), 32'd1);
    else q16.push_back({d, co, un});
    @(posedge clk);
    #1 iv16 = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    int g;
    g = 0;
    while ((q4.size() + q8.size() + q16.size()) != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    chk(tag, 32'(q4.size() + q8.size() + q16.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitors: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ov4 && ordy4) begin
      chk("w4_unexpected_out", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) chk("w4_out", 32'({od4, c4, u4}), 32'(q4.pop_front()));
    end
    if (!rst && ov8 && ordy8) begin
      chk("w8_unexpected_out", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) chk("w8_out", 32'({od8, c8, u8}), 32'(q8.pop_front()));
    end
    if (!rst && ov16 && ordy16) begin
      chk("w16_unexpected_out", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) chk("w16_out", 32'({od16, c16, u16}), 32'(q16.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cw;
    logic [15:0] m;
    logic [15:0] dv[2];

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_in_ready", 32'(rdy4), 32'd1);
    chk("rst_out_regs", 32'({od4, c4, u4}), 32'd0);
    chk("rst_w16_out_valid", 32'(ov16), 32'd0);
    @(posedge clk);
    #1;

    // Clean word and its 2-cycle latency
    send4(8'hAA, 4'hB, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(ov4), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(ov4), 32'd1);
    @(posedge clk);
    #1;

    // Single errors (data bit and overall-parity bit), then a double error
    send4(8'h8A, 4'hB, 1'b1, 1'b0);
    send4(8'hAB, 4'hB, 1'b1, 1'b0);
    send4(8'h88, 4'h9, 1'b0, 1'b1);
    drain_all("drain_basic");

    // Stall with both stages full
    ordy4 = 1'b0;
    send4(8'hAA, 4'hB, 1'b0, 1'b0);
    send4(8'h8A, 4'hB, 1'b1, 1'b0);
    iv4 = 1'b1;
    code4 = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(rdy4), 32'd0);
      chk("stall_hold", 32'({ov4, od4, c4, u4}), 32'({1'b1, 4'hB, 1'b0, 1'b0}));
    end
    @(posedge clk);
    #1 ordy4 = 1'b1;
    send4(8'hAA, 4'hB, 1'b0, 1'b0);
    drain_all("drain_stall");

    // Reset with two entries in flight discards them
    ordy4 = 1'b0;
    send4(8'hAA, 4'hB, 1'b0, 1'b0);
    send4(8'h8A, 4'hB, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q4.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(ov4), 32'd0);
    chk("midrst_in_ready", 32'(rdy4), 32'd1);
    ordy4 = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_output", 32'(ov4), 32'd0);
    @(posedge clk);
    #1;

`ifdef HAMMING_SECDED_STATS_EN
    chk("cnt_reset", 32'({cc4, uc4}), 32'd0);
    for (int i = 0; i < 5; i++) send4(8'h8A, 4'hB, 1'b1, 1'b0);
    drain_all("drain_cnt");
    chk("corr_cnt_sat", 32'(cc4), 32'd3);
    chk("uncorr_cnt_idle", 32'(uc4), 32'd0);
    send4(8'h88, 4'h9, 1'b0, 1'b1);
    drain_all("drain_cnt_unc");
    chk("uncorr_cnt_one", 32'(uc4), 32'd1);
    send4(8'h8A, 4'hB, 1'b1, 1'b0);
    @(posedge clk);
    #1 clr4 = 1'b1;
    @(posedge clk);
    #1 clr4 = 1'b0;
    @(negedge clk);
    chk("clr_same_cycle_out", 32'(q4.size()), 32'd0);
    chk("clr_priority", 32'({cc4, uc4}), 32'd0);
    @(posedge clk);
    #1;
`endif

    // DATA_W=8: clean, all single and double flips, plus triple flips with s>=13
    dv[0] = 16'h005A;
    dv[1] = 16'h00C3;
    for (int v = 0; v < 2; v++) begin
      cw = enc(8, dv[v]);
      send8(cw[12:0], dv[v][7:0], 1'b0, 1'b0);
      for (int i = 0; i < 13; i++) begin
        m = 16'h1 << i;
        send8(cw[12:0] ^ m[12:0], dv[v][7:0], 1'b1, 1'b0);
      end
      for (int i = 0; i < 13; i++) begin
        for (int j = i + 1; j < 13; j++) begin
          m = (16'h1 << i) | (16'h1 << j);
          send8(cw[12:0] ^ m[12:0], ext(8, cw ^ m), 1'b0, 1'b1);
        end
      end
      m = 16'h0112;
      send8(cw[12:0] ^ m[12:0], ext(8, cw ^ m), 1'b0, 1'b1);
      m = 16'h0114;
      send8(cw[12:0] ^ m[12:0], ext(8, cw ^ m), 1'b0, 1'b1);
      m = 16'h0118;
      send8(cw[12:0] ^ m[12:0], ext(8, cw ^ m), 1'b0, 1'b1);
    end
    drain_all("drain_w8");

    // DATA_W=11: clean, all single and double flips
    dv[0] = 16'h05A5;
    dv[1] = 16'h0733;
    for (int v = 0; v < 2; v++) begin
      cw = enc(11, dv[v]);
      send16(cw, dv[v][10:0], 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
        m = 16'h1 << i;
        send16(cw ^ m, dv[v][10:0], 1'b1, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
        for (int j = i + 1; j < 16; j++) begin
          m = (16'h1 << i) | (16'h1 << j);
          send16(cw ^ m, 11'(ext(11, cw ^ m)), 1'b0, 1'b1);
        end
      end
    end
    drain_all("drain_w16");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
